// File: rtl/rv32i_mmio_resp.sv
// Data-side MMIO responder for the RV32I core: console TX FIFO drained over a
// valid/ready stream plus a 64-bit machine timer with compare interrupt.
module rv32i_mmio_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          PRESCALE   = 1
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic [31:0] I_MEM_ADDR,
  input  logic        I_MEM_WR,
  input  logic [3:0]  I_MEM_WR_STRB,
  input  logic [31:0] I_MEM_WR_DATA,
  output logic        O_SEL,
  output logic [31:0] O_MEM_RD_DATA,
  output logic        O_TX_VALID,
  output logic [7:0]  O_TX_DATA,
  input  logic        I_TX_READY,
  output logic        O_TIMER_IRQ
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] PRE_MAX = SW'(PRESCALE - 1);

  localparam logic [5:0] OFF_TXDATA   = 6'd0;
  localparam logic [5:0] OFF_STATUS   = 6'd1;
  localparam logic [5:0] OFF_MTIME_LO = 6'd2;
  localparam logic [5:0] OFF_MTIME_HI = 6'd3;
  localparam logic [5:0] OFF_CMP_LO   = 6'd4;
  localparam logic [5:0] OFF_CMP_HI   = 6'd5;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          tx_ovf;
  logic [63:0]   mtime, mtimecmp;
  logic [SW-1:0] pre_cnt;
  logic          irq;

  logic [5:0]  word;
  logic        wr_en, empty, full, push_req, pop, push_ok, ovf_set, ovf_clr, tick;
  logic [31:0] count_ext;
  logic [7:0]  count_field;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int k = 0; k < 4; k++)
      if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
    return res;
  endfunction

  assign word             = I_MEM_ADDR[7:2];
  assign unused_addr_bits = ^I_MEM_ADDR[1:0];
  assign O_SEL            = (I_MEM_ADDR[31:8] == BASE_ADDR[31:8]);
  assign wr_en            = I_MEM_WR & O_SEL;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign push_req = wr_en && (word == OFF_TXDATA) && I_MEM_WR_STRB[0];
  assign pop      = !empty && I_TX_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr_en && (word == OFF_STATUS) && I_MEM_WR_STRB[0] && I_MEM_WR_DATA[2];
  assign tick     = (pre_cnt == PRE_MAX);

  always_ff @(posedge I_CLK) begin
    if (!I_RST && push_ok) fifo_mem[wr_ptr] <= I_MEM_WR_DATA[7:0];
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
    end
  end

  // Software writes to mtime take priority over the tick; halves carry nothing.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      pre_cnt  <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      irq      <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (wr_en && word == OFF_MTIME_LO)
        mtime[31:0] <= merge_bytes(mtime[31:0], I_MEM_WR_DATA, I_MEM_WR_STRB);
      else if (wr_en && word == OFF_MTIME_HI)
        mtime[63:32] <= merge_bytes(mtime[63:32], I_MEM_WR_DATA, I_MEM_WR_STRB);
      else if (tick)
        mtime <= mtime + 64'd1;
      if (wr_en && word == OFF_CMP_LO)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], I_MEM_WR_DATA, I_MEM_WR_STRB);
      if (wr_en && word == OFF_CMP_HI)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], I_MEM_WR_DATA, I_MEM_WR_STRB);
      irq <= (mtime >= mtimecmp);
    end
  end

  assign count_ext   = 32'(count);
  assign count_field = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];

  always_comb begin
    O_MEM_RD_DATA = '0;
    if (O_SEL) begin
      case (word)
        OFF_STATUS:   O_MEM_RD_DATA = {16'h0, count_field, 4'h0, irq, tx_ovf, full, empty};
        OFF_MTIME_LO: O_MEM_RD_DATA = mtime[31:0];
        OFF_MTIME_HI: O_MEM_RD_DATA = mtime[63:32];
        OFF_CMP_LO:   O_MEM_RD_DATA = mtimecmp[31:0];
        OFF_CMP_HI:   O_MEM_RD_DATA = mtimecmp[63:32];
        default:      O_MEM_RD_DATA = '0;
      endcase
    end
  end

  assign O_TX_VALID  = !empty;
  assign O_TX_DATA   = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign O_TIMER_IRQ = irq;

endmodule
